// File: rtl/ebi_bank_arbiter_if.sv
// Signal bundle between the two core decode ports, the shared register bank and
// the arbiter. The slave modport is the arbiter's view; master is its environment.
interface ebi_bank_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic          a_re_i;
  logic          a_we_i;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i;
  logic [DW-1:0] a_rdata_o;
  logic          a_ack_o;
  logic          a_ovr_o;

  logic          b_re_i;
  logic          b_we_i;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i;
  logic [DW-1:0] b_rdata_o;
  logic          b_ack_o;
  logic          b_ovr_o;

  logic          bank_re_o;
  logic          bank_we_o;
  logic [AW-1:0] bank_addr_o;
  logic [DW-1:0] bank_wdata_o;
  logic [DW-1:0] bank_rdata_i;
  logic          busy_o;

  modport slave (
    input  a_re_i, a_we_i, a_addr_i, a_wdata_i,
    output a_rdata_o, a_ack_o, a_ovr_o,
    input  b_re_i, b_we_i, b_addr_i, b_wdata_i,
    output b_rdata_o, b_ack_o, b_ovr_o,
    output bank_re_o, bank_we_o, bank_addr_o, bank_wdata_o,
    input  bank_rdata_i,
    output busy_o
  );

  modport master (
    output a_re_i, a_we_i, a_addr_i, a_wdata_i,
    input  a_rdata_o, a_ack_o, a_ovr_o,
    output b_re_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_rdata_o, b_ack_o, b_ovr_o,
    input  bank_re_o, bank_we_o, bank_addr_o, bank_wdata_o,
    output bank_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/ebi_bank_arbiter.sv
// Round-robin arbiter sharing one register bank between two asynchronous core ports.
// Index 0 of every per-port vector is core A, index 1 is core B.
module ebi_bank_arbiter #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  ebi_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t        state;
  state_t        state_next;

  logic [1:0]    re_in;
  logic [1:0]    we_in;
  logic [AW-1:0] addr_in   [2];
  logic [DW-1:0] wdata_in  [2];

  logic [1:0]    re_s1, re_s2, re_d;
  logic [1:0]    we_s1, we_s2, we_d;
  logic [1:0]    rd_rise, wr_rise, req;

  logic [1:0]    pend;
  logic [1:0]    is_wr;
  logic [1:0]    ovr;
  logic [1:0]    ack;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [DW-1:0] rdata     [2];

  logic          grant;
  logic          last_grant;
  logic          pick;
  logic          start;

  logic          bank_re;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;

  assign re_in       = {bus.b_re_i, bus.a_re_i};
  assign we_in       = {bus.b_we_i, bus.a_we_i};
  assign addr_in[0]  = bus.a_addr_i;
  assign addr_in[1]  = bus.b_addr_i;
  assign wdata_in[0] = bus.a_wdata_i;
  assign wdata_in[1] = bus.b_wdata_i;

  // Two flops resolve metastability; the third holds the previous level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_s1 <= '0;
      re_s2 <= '0;
      re_d  <= '0;
      we_s1 <= '0;
      we_s2 <= '0;
      we_d  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by one stage per clock.
      re_s1 <= re_in;
      re_s2 <= re_s1;
      re_d  <= re_s2;
      we_s1 <= we_in;
      we_s2 <= we_s1;
      we_d  <= we_s2;
    end
  end

  assign rd_rise = re_s2 & ~re_d;
  assign wr_rise = we_s2 & ~we_d;
  assign req     = rd_rise | wr_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_next = state;
    pick       = last_grant;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_next = ACCESS;
          pick       = (&pend) ? ~last_grant : pend[1];
        end
      end
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign start = (state == IDLE) && (|pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      is_wr      <= '0;
      ovr        <= '0;
      ack        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      bank_re    <= 1'b0;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      // NOTE: these two-entry holding registers are ordinary flops, not a RAM, so clearing them on reset costs nothing.
      for (int p = 0; p < 2; p++) begin
        req_addr[p]  <= '0;
        req_wdata[p] <= '0;
        rdata[p]     <= '0;
      end
    end else begin
      ack     <= '0;
      bank_re <= 1'b0;
      bank_we <= 1'b0;

      if (start) begin
        grant      <= pick;
        last_grant <= pick;
        bank_re    <= ~is_wr[pick];
        bank_we    <= is_wr[pick];
        bank_addr  <= req_addr[pick];
        bank_wdata <= req_wdata[pick];
      end

      if (state == CAPTURE) begin
        ack[grant]  <= 1'b1;
        pend[grant] <= 1'b0;
        if (!is_wr[grant]) rdata[grant] <= bus.bank_rdata_i;
      end

      // A new edge is judged against the pre-edge pend, so one arriving on the
      // completing port's capture edge still counts as an overrun.
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          if (pend[p]) begin
            ovr[p] <= 1'b1;
          end else begin
            pend[p]      <= 1'b1;
            is_wr[p]     <= wr_rise[p];
            req_addr[p]  <= addr_in[p];
            req_wdata[p] <= wdata_in[p];
          end
        end
      end
    end
  end

  assign bus.a_rdata_o    = rdata[0];
  assign bus.b_rdata_o    = rdata[1];
  assign bus.a_ack_o      = ack[0];
  assign bus.b_ack_o      = ack[1];
  assign bus.a_ovr_o      = ovr[0];
  assign bus.b_ovr_o      = ovr[1];
  assign bus.bank_re_o    = bank_re;
  assign bus.bank_we_o    = bank_we;
  assign bus.bank_addr_o  = bank_addr;
  assign bus.bank_wdata_o = bank_wdata;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_ebi_bank_arbiter.sv
// Bench for ebi_bank_arbiter: a transaction-schedule reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ebi_bank_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebi_bank_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  ebi_bank_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5) return 32'hDEAD_BEEF;
    if (i == 7) return 32'hCAFE_F00D;
    return 32'h5A00_0000 ^ DW'(i * 32'h0001_0203);
  endfunction

  // External bank: rdata is valid only in the cycle after a read strobe, noise otherwise.
  logic [DW-1:0] mem     [DEPTH];
  bit            written [DEPTH];
  always @(posedge clk) begin
    if (bus.bank_we_o) begin
      mem[bus.bank_addr_o]     <= bus.bank_wdata_o;
      written[bus.bank_addr_o] <= 1'b1;
    end
    if (bus.bank_re_o)
      bus.bank_rdata_i <= written[bus.bank_addr_o] ? mem[bus.bank_addr_o]
                                                   : init_word(int'(bus.bank_addr_o));
    else
      bus.bank_rdata_i <= $urandom;
  end

  // Reference model: requests are edges seen two samples late, the bank is a
  // resource reserved for 3 edges per grant, ties go to the port not served last.
  int            cyc = 0;
  logic          m_pend [2], m_wr [2], m_ovr [2], m_ack [2], pb [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2], m_rdata [2];
  logic          m_bank_re, m_bank_we, m_busy;
  logic [AW-1:0] m_bank_addr;
  logic [DW-1:0] m_bank_wdata;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_written [DEPTH];
  logic [3:0]    re_hist [2], we_hist [2];
  logic          rise_r, rise_w;
  int            m_last, m_cur, m_grant_edge, m_next_grant, m_cap_edge, m_write_edge;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        m_pend[p] = 0; m_wr[p] = 0; m_ovr[p] = 0; m_ack[p] = 0;
        m_addr[p] = '0; m_wdata[p] = '0; m_rdata[p] = '0;
        re_hist[p] = '0; we_hist[p] = '0;
      end
      m_bank_re = 0; m_bank_we = 0; m_busy = 0;
      m_bank_addr = '0; m_bank_wdata = '0;
      m_last = 1; m_cur = 0;
      m_grant_edge = -10; m_next_grant = 0; m_cap_edge = -1; m_write_edge = -1;
    end else begin
      cyc++;
      m_ack[0] = 0; m_ack[1] = 0;
      m_bank_re = 0; m_bank_we = 0;
      pb[0] = m_pend[0]; pb[1] = m_pend[1];

      if (cyc == m_write_edge) begin
        m_mem[m_bank_addr]     = m_bank_wdata;
        m_written[m_bank_addr] = 1'b1;
      end

      if (cyc == m_cap_edge) begin
        m_ack[m_cur]  = 1;
        m_pend[m_cur] = 0;
        if (!m_wr[m_cur])
          m_rdata[m_cur] = m_written[m_bank_addr] ? m_mem[m_bank_addr] : init_word(int'(m_bank_addr));
      end

      if (cyc >= m_next_grant && (pb[0] || pb[1])) begin
        if (pb[0] && pb[1]) m_cur = 1 - m_last;
        else                m_cur = pb[1] ? 1 : 0;
        m_last       = m_cur;
        m_grant_edge = cyc;
        m_next_grant = cyc + 3;
        m_cap_edge   = cyc + 2;
        m_bank_re    = !m_wr[m_cur];
        m_bank_we    = m_wr[m_cur];
        m_bank_addr  = m_addr[m_cur];
        m_bank_wdata = m_wdata[m_cur];
        if (m_wr[m_cur]) m_write_edge = cyc + 1;
      end

      for (int p = 0; p < 2; p++) begin
        re_hist[p] = {re_hist[p][2:0], (p == 0) ? bus.a_re_i : bus.b_re_i};
        we_hist[p] = {we_hist[p][2:0], (p == 0) ? bus.a_we_i : bus.b_we_i};
        rise_r = re_hist[p][2] && !re_hist[p][3];
        rise_w = we_hist[p][2] && !we_hist[p][3];
        if (rise_r || rise_w) begin
          if (pb[p]) begin
            m_ovr[p] = 1;
          end else begin
            m_pend[p]  = 1;
            m_wr[p]    = rise_w;
            m_addr[p]  = (p == 0) ? bus.a_addr_i : bus.b_addr_i;
            m_wdata[p] = (p == 0) ? bus.a_wdata_i : bus.b_wdata_i;
          end
        end
      end

      m_busy = (cyc == m_grant_edge) || (cyc == m_grant_edge + 1);
    end
  end

  // Per-cycle compare plus a small monitor used by the directed literal checks.
  bit            run = 0;
  int            acc_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0, a_ack_cyc = -1;
  int            last_acc_cyc = -1, prev_acc_cyc = -1;
  logic [AW-1:0] last_acc_addr = '0, prev_acc_addr = '0;
  logic [DW-1:0] last_acc_wdata = '0;
  logic          last_acc_we = 1'b0;

  initial forever begin
    @(negedge clk);
    if (run) begin
      check("a_ack",      bus.a_ack_o,      m_ack[0]);
      check("b_ack",      bus.b_ack_o,      m_ack[1]);
      check("a_ovr",      bus.a_ovr_o,      m_ovr[0]);
      check("b_ovr",      bus.b_ovr_o,      m_ovr[1]);
      check("a_rdata",    bus.a_rdata_o,    m_rdata[0]);
      check("b_rdata",    bus.b_rdata_o,    m_rdata[1]);
      check("bank_re",    bus.bank_re_o,    m_bank_re);
      check("bank_we",    bus.bank_we_o,    m_bank_we);
      check("bank_addr",  bus.bank_addr_o,  m_bank_addr);
      check("bank_wdata", bus.bank_wdata_o, m_bank_wdata);
      check("busy",       bus.busy_o,       m_busy);
      if (rst_n) begin
        if (bus.bank_re_o || bus.bank_we_o) begin
          acc_cnt++;
          prev_acc_cyc   = last_acc_cyc;
          prev_acc_addr  = last_acc_addr;
          last_acc_cyc   = cyc;
          last_acc_addr  = bus.bank_addr_o;
          last_acc_wdata = bus.bank_wdata_o;
          last_acc_we    = bus.bank_we_o;
        end
        if (bus.a_ack_o) begin
          a_ack_cnt++;
          a_ack_cyc = cyc;
        end
        if (bus.b_ack_o) b_ack_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic re, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (p == 0) begin
      bus.a_re_i = re; bus.a_we_i = we; bus.a_addr_i = addr; bus.a_wdata_i = wdata;
    end else begin
      bus.b_re_i = re; bus.b_we_i = we; bus.b_addr_i = addr; bus.b_wdata_i = wdata;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic rand_port(input int p);
    logic          re, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            kind;
    re    = (p == 0) ? bus.a_re_i    : bus.b_re_i;
    we    = (p == 0) ? bus.a_we_i    : bus.b_we_i;
    addr  = (p == 0) ? bus.a_addr_i  : bus.b_addr_i;
    wdata = (p == 0) ? bus.a_wdata_i : bus.b_wdata_i;
    if (!re && !we) begin
      if ($urandom_range(4) == 0) begin
        kind = int'($urandom_range(2));
        set_port(p, kind != 1, kind != 0, AW'($urandom), $urandom);
      end
    end else if ($urandom_range(2) == 0) begin
      set_port(p, 1'b0, 1'b0, addr, wdata);
    end else if (!we && $urandom_range(7) == 0) begin
      set_port(p, re, 1'b1, addr, wdata);
    end
  endtask

  int k, base_acc, base_ack;

  initial begin
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    run = 1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(1);

    check("rst_bank_addr", bus.bank_addr_o, 0);
    check("rst_a_rdata",   bus.a_rdata_o,   0);
    check("rst_busy",      bus.busy_o,      0);

    // A read of 0x05, strobe held 6 cycles.
    k = cyc + 1;
    set_port(0, 1'b1, 1'b0, 6'h05, '0);
    tick(6);
    set_port(0, 1'b0, 1'b0, 6'h05, '0);
    tick(6);
    check("rd_access_cyc",  last_acc_cyc,  k + 3);
    check("rd_access_addr", last_acc_addr, 6'h05);
    check("rd_ack_cyc",     a_ack_cyc,     k + 5);
    check("rd_data",        bus.a_rdata_o, 32'hDEAD_BEEF);
    check("rd_b_ack_cnt",   b_ack_cnt,     0);
    check("rd_acc_cnt",     acc_cnt,       1);

    // B write of 0x12345678 to 0x3F.
    set_port(1, 1'b0, 1'b1, 6'h3F, 32'h1234_5678);
    tick(4);
    set_port(1, 1'b0, 1'b0, 6'h3F, 32'h1234_5678);
    tick(6);
    check("wr_access_we",   last_acc_we,    1);
    check("wr_access_addr", last_acc_addr,  6'h3F);
    check("wr_access_data", last_acc_wdata, 32'h1234_5678);
    check("wr_b_ack_cnt",   b_ack_cnt,      1);
    check("wr_b_rdata",     bus.b_rdata_o,  0);

    // Tie right after reset: A wins, B follows 3 cycles later.
    do_reset();
    k = cyc + 1;
    set_port(0, 1'b1, 1'b0, 6'h01, '0);
    set_port(1, 1'b0, 1'b1, 6'h02, 32'hA5A5_0002);
    tick(3);
    set_port(0, 1'b0, 1'b0, 6'h01, '0);
    set_port(1, 1'b0, 1'b0, 6'h02, 32'hA5A5_0002);
    tick(10);
    check("tie1_first_addr",  prev_acc_addr, 6'h01);
    check("tie1_first_cyc",   prev_acc_cyc,  k + 3);
    check("tie1_second_addr", last_acc_addr, 6'h02);
    check("tie1_second_cyc",  last_acc_cyc,  k + 6);

    // A alone, then a second tie which B must win.
    set_port(0, 1'b1, 1'b0, 6'h03, '0);
    tick(2);
    set_port(0, 1'b0, 1'b0, 6'h03, '0);
    tick(8);
    set_port(0, 1'b1, 1'b0, 6'h04, '0);
    set_port(1, 1'b0, 1'b1, 6'h06, 32'h0000_0066);
    tick(3);
    set_port(0, 1'b0, 1'b0, 6'h04, '0);
    set_port(1, 1'b0, 1'b0, 6'h06, 32'h0000_0066);
    tick(10);
    check("tie2_first_addr",  prev_acc_addr, 6'h06);
    check("tie2_second_addr", last_acc_addr, 6'h04);
    check("tie2_spacing",     last_acc_cyc - prev_acc_cyc, 3);

    // Overrun: second A edge lands while the first is still pending.
    base_acc = acc_cnt;
    base_ack = a_ack_cnt;
    set_port(0, 1'b1, 1'b0, 6'h08, '0);
    tick(1);
    set_port(0, 1'b0, 1'b0, 6'h08, '0);
    tick(1);
    set_port(0, 1'b1, 1'b0, 6'h08, '0);
    tick(3);
    set_port(0, 1'b0, 1'b0, 6'h08, '0);
    tick(10);
    check("ovr_flag",    bus.a_ovr_o,          1);
    check("ovr_acc_cnt", acc_cnt - base_acc,   1);
    check("ovr_ack_cnt", a_ack_cnt - base_ack, 1);

    // Strobe held 20 cycles yields a single access.
    base_acc = acc_cnt;
    base_ack = a_ack_cnt;
    set_port(0, 1'b1, 1'b0, 6'h09, '0);
    tick(20);
    set_port(0, 1'b0, 1'b0, 6'h09, '0);
    tick(8);
    check("held_acc_cnt", acc_cnt - base_acc,   1);
    check("held_ack_cnt", a_ack_cnt - base_ack, 1);
    check("held_ovr",     bus.a_ovr_o,          1);

    // Reset asserted mid-ACCESS: strobe drops at once, request is lost.
    set_port(0, 1'b1, 1'b0, 6'h07, '0);
    tick(4);
    check("rst_mid_in_access", bus.bank_re_o, 1);
    set_port(0, 1'b0, 1'b0, 6'h07, '0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bank_re", bus.bank_re_o, 0);
    check("rst_mid_busy",    bus.busy_o,    0);
    check("rst_mid_ovr",     bus.a_ovr_o,   0);
    tick(2);
    @(negedge clk);
    #1 rst_n = 1'b1;
    base_ack = a_ack_cnt;
    tick(8);
    check("rst_mid_no_ack", a_ack_cnt - base_ack, 0);
    check("rst_mid_rdata",  bus.a_rdata_o,        0);
    set_port(0, 1'b1, 1'b0, 6'h07, '0);
    tick(3);
    set_port(0, 1'b0, 1'b0, 6'h07, '0);
    tick(6);
    check("rst_after_ack",   a_ack_cnt - base_ack, 1);
    check("rst_after_rdata", bus.a_rdata_o,        32'hCAFE_F00D);

    // Randomized traffic on both ports with one asynchronous reset in the middle.
    for (int i = 0; i < 2500; i++) begin
      rand_port(0);
      rand_port(1);
      if (i == 1200) begin
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
